// File: rtl/display_pkg.sv
// -----------------------------------------------------------------------------
// display_pkg
// Shared types and defaults for the multiplexed display scan controller.
//   scan_state_e  : BLANK / SHOW phase of a digit slot
//   digit_t       : 2-bit index of the scanned digit (0 = leftmost)
//   SLOT_CYC_DEF  : default clk cycles per digit slot
//   BLANK_CYC_DEF : default blanked cycles at the start of each slot
//   digit_nibble  : selects the nibble of a 16-bit value for a given digit
// -----------------------------------------------------------------------------
package display_pkg;

    localparam int SLOT_CYC_DEF  = 50000;
    localparam int BLANK_CYC_DEF = 2500;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_e;

    typedef logic [1:0] digit_t;

    // Digit 0 is the leftmost digit and lives in the top nibble.
    function automatic logic [3:0] digit_nibble(input logic [15:0] value, input digit_t d);
        logic [3:0] nib;
        case (d)
            2'd0:    nib = value[15:12];
            2'd1:    nib = value[11:8];
            2'd2:    nib = value[7:4];
            default: nib = value[3:0];
        endcase
        return nib;
    endfunction

endpackage

// File: rtl/display_scan_ctrl_if.sv
// -----------------------------------------------------------------------------
// display_scan_ctrl_if
// Valid/ready load channel carrying a new 16-bit display value.
//   load_valid : producer offers load_data
//   load_data  : four nibbles, [15:12] = digit 0 ... [3:0] = digit 3
//   load_ready : controller can accept load_data
// Modports: master = producer side, slave = controller side.
// -----------------------------------------------------------------------------
interface display_scan_ctrl_if;

    logic        load_valid;
    logic [15:0] load_data;
    logic        load_ready;

    modport master (
        output load_valid,
        output load_data,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_data,
        output load_ready
    );

endinterface

// File: rtl/slot_timer.sv
// -----------------------------------------------------------------------------
// slot_timer
// Free-running digit slot counter, 0..SLOT_CYC-1 then wrap.
//   clk, reset_n : system clock, asynchronous active-low reset
//   enable       : counter advances only while high (holds at 0 otherwise)
//   slot_end     : high in the last cycle of a slot (the wrap cycle)
//   blank_end    : high in the last blanked cycle of a slot
// -----------------------------------------------------------------------------
module slot_timer
    import display_pkg::*;
#(
    parameter int SLOT_CYC  = SLOT_CYC_DEF,
    parameter int BLANK_CYC = BLANK_CYC_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    output logic slot_end,
    output logic blank_end
);

    localparam int CW = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;
    localparam logic [CW-1:0] LAST_CNT   = CW'(SLOT_CYC - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: wrap at the slot end, hold while the scan is not running.
    always_comb begin
        cnt_d = cnt_q;
        if (enable) begin
            cnt_d = (cnt_q == LAST_CNT) ? '0 : cnt_q + CW'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Strobes are gated so nothing fires while the counter is parked at 0.
    assign slot_end  = enable && (cnt_q == LAST_CNT);
    assign blank_end = enable && (cnt_q == BLANK_LAST);

endmodule

// File: rtl/display_scan_ctrl.sv
// -----------------------------------------------------------------------------
// display_scan_ctrl
// Sequences a 4-digit multiplexed display: steps the digit index once per
// slot, blanks the first BLANK_CYC cycles of every slot and selects the
// nibble to decode from either the external ID source or the active buffer.
// New display values are double-buffered and only take effect at a frame
// boundary so a frame is never drawn with mixed data.
//   clk, reset_n : system clock, asynchronous active-low reset
//   src_sel      : 0 = show idnum, 1 = show the active buffer
//   idnum        : nibble from the external ID source for the current digit
//   load_if      : valid/ready load channel (slave side)
//   digit        : scanned digit index
//   digit_en     : current digit may be lit (low while blanking)
//   nibble       : value handed to the external segment decoder
//   frame_start  : one-cycle pulse in the first cycle of digit 0
// -----------------------------------------------------------------------------
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int SLOT_CYC  = SLOT_CYC_DEF,
    parameter int BLANK_CYC = BLANK_CYC_DEF
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      src_sel,
    input  logic [3:0]                idnum,
    display_scan_ctrl_if.slave        load_if,
    output digit_t                    digit,
    output logic                      digit_en,
    output logic [3:0]                nibble,
    output logic                      frame_start
);

    scan_state_e state_q, state_d;
    digit_t      digit_q, digit_d;
    logic        run_q;
    logic        digit_en_q, digit_en_d;
    logic        frame_start_q, frame_start_d;
    logic        pending_q, pending_d;
    logic        load_ready_q, load_ready_d;
    logic [15:0] shadow_q, shadow_d;
    logic [15:0] active_q, active_d;

    logic slot_end;
    logic blank_end;
    logic accept;
    logic commit;

    // The counter is held at 0 for the single cycle after reset release so
    // the first slot starts cleanly together with the first frame_start.
    slot_timer #(
        .SLOT_CYC  (SLOT_CYC),
        .BLANK_CYC (BLANK_CYC)
    ) u_slot_timer (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (run_q),
        .slot_end  (slot_end),
        .blank_end (blank_end)
    );

    // State and datapath registers; everything clears on reset so a pending
    // load is discarded and scanning restarts at digit 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= BLANK;
            digit_q       <= '0;
            run_q         <= 1'b0;
            digit_en_q    <= 1'b0;
            frame_start_q <= 1'b0;
            pending_q     <= 1'b0;
            load_ready_q  <= 1'b0;
            shadow_q      <= '0;
            active_q      <= '0;
        end else begin
            state_q       <= state_d;
            digit_q       <= digit_d;
            run_q         <= 1'b1;
            digit_en_q    <= digit_en_d;
            frame_start_q <= frame_start_d;
            pending_q     <= pending_d;
            load_ready_q  <= load_ready_d;
            shadow_q      <= shadow_d;
            active_q      <= active_d;
        end
    end

    // Next-state logic: blank until the blanking window ends, then show
    // until the slot wraps.
    always_comb begin
        state_d = state_q;
        case (state_q)
            BLANK:   if (blank_end) state_d = SHOW;
            SHOW:    if (slot_end)  state_d = BLANK;
            default: state_d = BLANK;
        endcase
    end

    // Output logic: digit_en follows the next state so the registered copy
    // matches the current state exactly; the digit only moves at slot end,
    // which is always in the lit phase's last cycle, so it lands in BLANK.
    always_comb begin
        digit_en_d    = (state_d == SHOW);
        digit_d       = slot_end ? digit_q + 2'd1 : digit_q;
        frame_start_d = !run_q || (slot_end && (digit_q == 2'd3));
    end

    // Load buffering: accept only while ready, commit shadow to active at the
    // edge that raises frame_start. Accept and commit never coincide because
    // ready is low whenever something is pending, so data accepted at a frame
    // boundary waits for the next one.
    always_comb begin
        accept       = load_if.load_valid && load_ready_q;
        commit       = frame_start_d && pending_q;
        shadow_d     = accept ? load_if.load_data : shadow_q;
        active_d     = commit ? shadow_q : active_q;
        pending_d    = pending_q;
        if (commit) begin
            pending_d = 1'b0;
        end else if (accept) begin
            pending_d = 1'b1;
        end
        load_ready_d = !pending_d;
    end

    assign load_if.load_ready = load_ready_q;
    assign digit              = digit_q;
    assign digit_en           = digit_en_q;
    assign frame_start        = frame_start_q;
    assign nibble             = src_sel ? digit_nibble(active_q, digit_q) : idnum;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_display_scan_ctrl
// Self-checking bench for display_scan_ctrl with SLOT_CYC = 8, BLANK_CYC = 2.
// A cycle-level reference model computes the expected outputs for each cycle
// as stimulus is driven and queues them; a monitor pops and compares on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_display_scan_ctrl;

    localparam int SLOT  = 8;
    localparam int BLANK = 2;
    localparam int FRAME = 4 * SLOT;

    typedef struct {
        int          t;
        logic [1:0]  digit;
        logic        en;
        logic        fs;
        logic        ready;
        logic [3:0]  nib;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        src_sel;
    logic [3:0]  idnum;
    logic [1:0]  digit;
    logic        digit_en;
    logic [3:0]  nibble;
    logic        frame_start;

    display_scan_ctrl_if load_bus ();

    display_scan_ctrl #(
        .SLOT_CYC  (SLOT),
        .BLANK_CYC (BLANK)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .src_sel     (src_sel),
        .idnum       (idnum),
        .load_if     (load_bus),
        .digit       (digit),
        .digit_en    (digit_en),
        .nibble      (nibble),
        .frame_start (frame_start)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    int   checks = 0;
    int   fails  = 0;
    exp_t sb_q[$];
    exp_t mon_e;

    // Reference model state.
    bit          m_run;
    int          m_t;
    logic        m_pending;
    logic        m_ready;
    logic [15:0] m_shadow;
    logic [15:0] m_active;
    logic [3:0]  id_table [4] = '{4'd4, 4'd8, 4'd0, 4'd0};

    // Single comparison point for every check in the bench.
    task automatic checkOutput(input string tag, input logic [15:0] got,
                               input logic [15:0] exp, input int t);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s t=%0d got=%h expected=%h", tag, t, got, exp);
        end
    endtask

    function automatic logic [3:0] model_nibble(input logic [15:0] v, input int d);
        logic [15:0] s;
        s = v >> (12 - 4 * d);
        return s[3:0];
    endfunction

    task automatic modelReset();
        m_run     = 1'b0;
        m_t       = -1;
        m_pending = 1'b0;
        m_ready   = 1'b0;
        m_shadow  = '0;
        m_active  = '0;
    endtask

    // Model of one rising edge, using the inputs that were held across it.
    task automatic modelEdge();
        logic acc;
        if (!m_run) begin
            m_run   = 1'b1;
            m_t     = 0;
            m_ready = 1'b1;
        end else begin
            acc = load_bus.load_valid && m_ready;
            m_t++;
            if ((m_t % FRAME) == 0 && m_pending) begin
                m_active  = m_shadow;
                m_pending = 1'b0;
            end
            if (acc) begin
                m_shadow  = load_bus.load_data;
                m_pending = 1'b1;
            end
            m_ready = !m_pending;
        end
    endtask

    // One clock cycle: advance the model past the edge, drive this cycle's
    // inputs, then queue what the DUT should show for the rest of the cycle.
    task automatic applyStimulus(input logic rst_n_val, input logic sel,
                                 input logic valid, input logic [15:0] data);
        exp_t e;
        int   d;
        @(posedge clk);
        #1;
        if (reset_n) modelEdge();
        reset_n = rst_n_val;
        if (!rst_n_val) modelReset();
        d                   = m_run ? (m_t / SLOT) % 4 : 0;
        src_sel             = sel;
        load_bus.load_valid = valid;
        load_bus.load_data  = data;
        idnum               = id_table[d];
        e.t     = m_t;
        e.digit = 2'(d);
        e.en    = m_run && ((m_t % SLOT) >= BLANK);
        e.fs    = m_run && ((m_t % FRAME) == 0);
        e.ready = m_ready;
        e.nib   = sel ? model_nibble(m_active, d) : id_table[d];
        sb_q.push_back(e);
    endtask

    // Run idle cycles until the next applyStimulus call lands on cycle target.
    task automatic runTo(input int target, input logic sel);
        int guard = 0;
        while (m_t < target - 1 && guard < 1000) begin
            applyStimulus(1'b1, sel, 1'b0, 16'h0000);
            guard++;
        end
    endtask

    // Monitor: compare queued expectations mid-cycle, away from the edge.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            checkOutput("digit",       16'(digit),                mon_e.t == mon_e.t ? 16'(mon_e.digit) : 16'h0, mon_e.t);
            checkOutput("digit_en",    16'(digit_en),             16'(mon_e.en),    mon_e.t);
            checkOutput("frame_start", 16'(frame_start),          16'(mon_e.fs),    mon_e.t);
            checkOutput("load_ready",  16'(load_bus.load_ready),  16'(mon_e.ready), mon_e.t);
            checkOutput("nibble",      16'(nibble),               16'(mon_e.nib),   mon_e.t);
        end
    end

    initial begin
        reset_n             = 1'b0;
        src_sel             = 1'b0;
        idnum               = 4'd0;
        load_bus.load_valid = 1'b0;
        load_bus.load_data  = 16'h0000;
        modelReset();

        // Reset, release, then plain scanning of the ID source.
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
        runTo(36, 1'b0);

        // Buffer display: mid-frame load waits for the next frame.
        runTo(40, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1, 16'h1234);

        // Load offered in the cycle that ends on a frame boundary.
        runTo(95, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1, 16'hABCD);

        // Loads while pending are dropped.
        runTo(100, 1'b1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, 16'h5555);
        end

        // Pending load, then reset during digit 2 SHOW.
        runTo(130, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1, 16'h9999);
        runTo(148, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
        runTo(40, 1'b1);

        @(negedge clk);
        #1;
        checkOutput("scoreboard_drained", 16'(sb_q.size()), 16'h0000, m_t);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    // Hard time limit so the bench can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL timeout t=%0d got=running expected=finished", m_t);
        $fatal(1, "[TB] time limit reached");
    end

endmodule

// File: doc/display_scan_ctrl.md
DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 Parameter SLOT_CYC, default 50000, clk cycles per digit slot (1 kHz slot rate at 50 MHz).
REQ-002 Parameter BLANK_CYC, default 2500, blanked cycles at the start of each slot; legal range 1 <= BLANK_CYC < SLOT_CYC.
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 src_sel  input  1  0 = display the idnum input, 1 = display the internal active buffer.
REQ-006 idnum  input  4  nibble returned by the ID digit source for the current digit.
REQ-007 load_valid  input  1  new 16-bit display value offered.
REQ-008 load_data  input  16  four nibbles; [15:12] = digit 0 (leftmost) ... [3:0] = digit 3.
REQ-009 load_ready  output  1  controller can accept load_data.
REQ-010 digit  output  2  currently scanned digit index; drives the ID source and the digit decoder.
REQ-011 digit_en  output  1  high while the current digit may be lit; low during blanking.
REQ-012 nibble  output  4  value to be segment-decoded for the current digit.
REQ-013 frame_start  output  1  one-cycle pulse marking the start of digit 0.

Function
REQ-014 The slot counter SHALL count 0..SLOT_CYC-1, then wrap to 0; the wrap cycle is the slot end.
REQ-015 The FSM SHALL have two states: BLANK (counter < BLANK_CYC) and SHOW (counter >= BLANK_CYC).
REQ-016 BLANK->SHOW SHALL occur when the counter reaches BLANK_CYC-1; SHOW->BLANK SHALL occur at slot end.
REQ-017 digit_en SHALL be registered, high only in SHOW, low for exactly BLANK_CYC cycles per slot.
REQ-018 digit SHALL advance by 1 at slot end with 3->0 wrap, so the new digit appears in the first BLANK cycle of the next slot.
REQ-019 digit SHALL never change while digit_en is high.
REQ-020 frame_start SHALL pulse high for one cycle, coincident with the first cycle in which digit = 0.
REQ-021 nibble SHALL be combinational: idnum when src_sel = 0, else active[15-4*digit -: 4].
REQ-022 The controller SHALL have a 16-bit shadow register, a pending flag, and a 16-bit active register.
REQ-023 A load SHALL be accepted when load_valid && load_ready: load_data goes to shadow and pending is set.
REQ-024 load_ready SHALL be registered and equal to !pending; it drops the cycle after an accept.
REQ-025 When frame_start is being asserted and pending = 1, shadow SHALL be copied to active and pending cleared, so that active changes only between frames.
REQ-026 Simultaneous accept and frame boundary: the accepted data commits at the next frame boundary, not the current one.
REQ-027 load_valid while load_ready = 0 SHALL be ignored; data is not held and no error is flagged.
REQ-028 A change of src_sel SHALL affect nibble immediately; scan timing is unaffected.

Reset
REQ-029 While reset_n = 0: counter = 0, state = BLANK, digit = 0, digit_en = 0, frame_start = 0, shadow = 0, active = 16'h0000, pending = 0, load_ready = 0.
REQ-030 On the first clk edge after reset_n rises: load_ready = 1, and scanning starts from digit 0, BLANK, counter 0.
REQ-031 Reset asserted mid-slot or mid-load SHALL discard pending data and restart scanning from digit 0.

Structure
REQ-032 The shared package display_pkg SHALL hold the state enum (BLANK, SHOW), the digit index type (2-bit), and the default SLOT_CYC/BLANK_CYC constants.
REQ-033 One sub-module, slot_timer, SHALL implement the parameterised slot counter and provide the slot_end and blank_end strobes.
REQ-034 The ID source and the segment and digit decoders remain external; this block only sequences them.

Verification (SLOT_CYC = 8, BLANK_CYC = 2)
REQ-035 Release reset -> load_ready = 1 next cycle; digit sequence 0,1,2,3,0 with 8 cycles each; digit_en pattern 0,0,1,1,1,1,1,1 per slot.
REQ-036 src_sel = 0, idnum driven 4,8,0,0 for digits 0..3 -> nibble = 4,8,0,0 in step with digit.
REQ-037 src_sel = 1, load 16'h1234 mid-frame -> load_ready low; nibble stays 0 until the next frame_start, then shows 1,2,3,4.
REQ-038 load 16'hABCD accepted in the same cycle frame_start rises -> the current frame shows the old value; ABCD appears from the following frame_start.
REQ-039 Second load_valid while pending -> ignored; only the first value is displayed.
REQ-040 reset_n pulsed low during digit 2 SHOW with a load pending -> outputs take reset values; active = 0; scanning restarts at digit 0.
